dividend_reconstruct_mul: RTL and testbench

Sequential shift-add multiply-accumulate unit computing P = q·M + R on unsigned operands. It is the inverse of the non-restoring divider: it takes quotient q, divisor M and remainder R, all at the divider's output widths, and rebuilds the dividend. It is used to self-check divider results and as a general small multiplier. A start/busy/done handshake controls it, and it produces one result every N+1 cycles at best.

---
 rtl/dividend_reconstruct_mul.sv | 91 +++++++++
 tb/tb_dividend_reconstruct_mul.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dividend_reconstruct_mul.sv
// Shift-add multiply-accumulate: rebuilds a dividend as P = q*M + R from divider outputs.
// One operand bit is consumed per RUN cycle; start/busy/done handshake.
module dividend_reconstruct_mul #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   q,
  input  logic [N:0]     M,
  input  logic [N:0]     R,
  output logic           busy,
  output logic           done,
  output logic [2*N:0]   P
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned PW   = 2 * N + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [N:0]      mreg_q, mreg_d;
  logic [N-1:0]    qreg_q, qreg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;

  logic [PW-1:0]   addend;
  logic [PW-1:0]   sum;

  always_comb begin
    state_d = state_q;
    mreg_d  = mreg_q;
    qreg_d  = qreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    // Partial product for the current multiplier bit, aligned by iteration count.
    addend = qreg_q[0] ? ({{N{1'b0}}, mreg_q} << cnt_q) : '0;
    sum    = acc_q + addend;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mreg_d  = M;
          qreg_d  = q;
          acc_d   = {{N{1'b0}}, R};
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d  = sum;
        qreg_d = qreg_q >> 1;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          p_d     = sum;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      mreg_q  <= '0;
      qreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mreg_q  <= mreg_d;
      qreg_q  <= qreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign P    = p_q;

endmodule

// File: tb/tb_dividend_reconstruct_mul.sv
// Directed bench for dividend_reconstruct_mul (N=4) with an expected-result queue.
module tb_dividend_reconstruct_mul;

  localparam int unsigned N = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   q;
  logic [N:0]     M;
  logic [N:0]     R;
  logic           busy;
  logic           done;
  logic [2*N:0]   P;

  int checks;
  int errors;
  int done_cnt;
  logic [31:0] exp_q[$];

  dividend_reconstruct_mul #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q     (q),
    .M     (M),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input int unsigned qq, input int unsigned mm,
                                        input int unsigned rr);
    return qq * mm + rr;
  endfunction

  // Drive operands with start for one edge and record the expected result.
  task automatic start_op(input int unsigned qq, input int unsigned mm, input int unsigned rr,
                          input string tag);
    start = 1'b1;
    q     = qq[N-1:0];
    M     = mm[N:0];
    R     = rr[N:0];
    exp_q.push_back(model(qq, mm, rr));
    step();
    start = 1'b0;
    check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
  endtask

  // Step until done (bounded), then compare latency and pop the expected result.
  task automatic wait_done(input string tag, input int exp_lat, output int lat);
    logic [31:0] e;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (busy === 1'b1 && done === 1'b1) check({tag, "_busy_done_overlap"}, 32'd1, 32'd0);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_done"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_P"}, {23'd0, P}, e);
      end
    end
  endtask

  initial begin
    int lat;
    int dc;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    rst   = 1'b0;
    start = 1'b0;
    q     = '0;
    M     = '0;
    R     = '0;

    // Reset state
    step();
    step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_P", {23'd0, P}, 32'd0);
    rst = 1'b1;

    // Basic: 2*5+1 = 11, also checked against the literal dividend 4'b1011
    start_op(2, 5, 1, "t1");
    wait_done("t1", 4, lat);
    check("t1_P_literal", {23'd0, P}, 32'd11);
    step();
    check("t1_done_pulse_ends", {31'd0, done}, 32'd0);

    // 4*3+2 = 14, exactly one done
    dc = done_cnt;
    start_op(4, 3, 2, "t2");
    wait_done("t2", 4, lat);
    check("t2_P_literal", {23'd0, P}, 32'd14);
    step();
    step();
    step();
    check("t2_single_done", done_cnt - dc, 32'd1);

    // Extremes
    start_op(15, 31, 31, "max");
    wait_done("max", 4, lat);
    check("max_P_literal", {23'd0, P}, 32'd496);
    step();
    start_op(0, 31, 7, "zeroq");
    wait_done("zeroq", 4, lat);
    check("zeroq_P_literal", {23'd0, P}, 32'd7);
    step();

    // Start pulsed with wild inputs during RUN must be ignored
    dc = done_cnt;
    start_op(3, 5, 0, "stress");
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      q     = 4'hF;
      M     = 5'h1F;
      R     = 5'($urandom);
      step();
      check("stress_busy_in_run", {31'd0, busy}, 32'd1);
      q     = 4'($urandom);
      M     = 5'($urandom);
    end
    start = 1'b0;
    wait_done("stress", 2, lat);
    check("stress_P_literal", {23'd0, P}, 32'd15);
    step();
    step();
    check("stress_no_second_op", {31'd0, busy}, 32'd0);
    check("stress_single_done", done_cnt - dc, 32'd1);

    // Back-to-back with start held high through the done cycle
    start = 1'b1;
    q     = 4'd1;
    M     = 5'd9;
    R     = 5'd2;
    exp_q.push_back(model(1, 9, 2));
    step();
    check("b2b_busy_first", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      step();
    end
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_P", {23'd0, P}, exp_q.pop_front());
    q = 4'd2;
    M = 5'd2;
    R = 5'd0;
    exp_q.push_back(model(2, 2, 0));
    step();
    start = 1'b0;
    check("b2b_busy_reasserts", {31'd0, busy}, 32'd1);
    check("b2b_done_drops", {31'd0, done}, 32'd0);
    wait_done("b2b2", 4, lat);
    check("b2b_done_spacing", lat + 1, N + 1);
    check("b2b_second_P_literal", {23'd0, P}, 32'd4);
    step();

    // Reset mid-operation: no done, P cleared
    dc    = done_cnt;
    start = 1'b1;
    q     = 4'd7;
    M     = 5'd3;
    R     = 5'd1;
    step();
    start = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_P", {23'd0, P}, 32'd0);
    rst = 1'b1;
    step();
    step();
    step();
    check("abort_no_done", done_cnt - dc, 32'd0);
    start_op(2, 5, 1, "after_abort");
    wait_done("after_abort", 4, lat);
    check("after_abort_P_literal", {23'd0, P}, 32'd11);
    step();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
